// File: rtl/sc_cfg_pkg.sv
// Shared types and constants for the scanconverter config commit scheduler.
package sc_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int unsigned N_REGS_DEF = 8;

  // Word index map of the live config vector
  localparam int unsigned CFG_MISC = 0;
  localparam int unsigned CFG_SL   = 1;
  localparam int unsigned CFG_SL2  = 2;
  localparam int unsigned CFG_HV   = 3;
  localparam int unsigned CFG_HV2  = 4;
  localparam int unsigned CFG_HV3  = 5;
  localparam int unsigned CFG_XY   = 6;
  localparam int unsigned CFG_XY2  = 7;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 2097152;
  localparam int unsigned TMO_CNT_W          = 21;

endpackage

// File: rtl/vsync_edge_det.sv
// Registered VSYNC sample plus combinational inactive->active edge strobe.
module vsync_edge_det #(
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic edge_c_o
);

  logic vs_q;

  // Previous-cycle VSYNC level, reset to the inactive level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vs_q <= ~VSYNC_POL;
    else         vs_q <= vsync_i;
  end

  assign edge_c_o = (vsync_i == VSYNC_POL) && (vs_q != VSYNC_POL);

endmodule

// File: rtl/sc_cfg_commit_sched.sv
// Frame-atomic config commit: shadow words are copied to cfg_o on an active VSYNC edge.
// Optional armed-state timeout enabled by defining CFG_COMMIT_TIMEOUT_EN.
module sc_cfg_commit_sched
  import sc_cfg_pkg::*;
#(
  parameter int unsigned N_REGS         = N_REGS_DEF,
  parameter int unsigned ADDR_W         = 3,
  parameter logic        VSYNC_POL      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                PCLK_i,
  input  logic                reset_n,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [31:0]         wr_data_i,
  input  logic                commit_req_i,
  input  logic                abort_i,
  input  logic                vsync_i,
  output logic [32*N_REGS-1:0] cfg_o,
  output logic                pending_o,
  output logic                armed_o,
  output logic                commit_done_o,
  output logic                timeout_o
);

  // The timeout counter must be able to reach TIMEOUT_CYCLES-1
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > (32'd1 << TMO_CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for the timeout counter");
  end

  state_e                state_q;
  logic [31:0]           shadow_q [N_REGS];
  logic [32*N_REGS-1:0]  cfg_q;
  logic                  pending_q;
  logic                  armed_q;
  logic                  done_q;
  logic                  vs_edge;
  logic                  wr_fire;
  logic                  wr_in_range;
  logic                  tmo_hit;

  vsync_edge_det #(
    .VSYNC_POL (VSYNC_POL)
  ) u_edge (
    .clk_i    (PCLK_i),
    .rst_ni   (reset_n),
    .vsync_i  (vsync_i),
    .edge_c_o (vs_edge)
  );

  assign wr_ready_o  = (state_q == IDLE);
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_in_range = 32'(wr_addr_i) < N_REGS;

  // Shadow word bank; out-of-range addresses match no word and are dropped
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < N_REGS; k++) shadow_q[k] <= '0;
    end else if (wr_fire) begin
      for (int unsigned k = 0; k < N_REGS; k++) begin
        if (32'(wr_addr_i) == k) shadow_q[k] <= wr_data_i;
      end
    end
  end

  // Commit FSM with registered status outputs and the live config copy
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      cfg_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_fire && wr_in_range) pending_q <= 1'b1;
          if (commit_req_i) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
          end
        end
        ARMED: begin
          if (abort_i) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
          end else if (vs_edge || tmo_hit) begin
            state_q <= COMMIT;
            armed_q <= 1'b0;
          end
        end
        COMMIT: begin
          for (int unsigned k = 0; k < N_REGS; k++) cfg_q[32*k +: 32] <= shadow_q[k];
          done_q    <= 1'b1;
          pending_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CFG_COMMIT_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q;
  logic                 by_tmo_q;
  logic                 tmo_flag_q;

  assign tmo_hit = (state_q == ARMED) && (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

  // Armed-cycle counter and sticky flag recording whether the last commit was forced
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q  <= '0;
      by_tmo_q   <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q == IDLE && commit_req_i) tmo_cnt_q <= '0;
      else if (state_q == ARMED)           tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
      if (state_q == ARMED && !abort_i && (vs_edge || tmo_hit)) by_tmo_q <= !vs_edge;
      if (state_q == COMMIT) tmo_flag_q <= by_tmo_q;
    end
  end

  assign timeout_o = tmo_flag_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign cfg_o         = cfg_q;
  assign pending_o     = pending_q;
  assign armed_o       = armed_q;
  assign commit_done_o = done_q;

endmodule

// File: tb/tb_sc_cfg_commit_sched.sv
// Directed bench for sc_cfg_commit_sched with a commit scoreboard.
module tb_sc_cfg_commit_sched;
  import sc_cfg_pkg::*;

  localparam int unsigned NR  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 32 * NR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          commit_req;
  logic          abort;
  logic          vsync;
  logic [CW-1:0] cfg_o;
  logic          pending_o;
  logic          armed_o;
  logic          commit_done_o;
  logic          timeout_o;

  always #5 clk = ~clk;

  sc_cfg_commit_sched #(
    .N_REGS         (NR),
    .ADDR_W         (AW),
    .VSYNC_POL      (1'b0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK_i        (clk),
    .reset_n       (rst_n),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready_o),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .commit_req_i  (commit_req),
    .abort_i       (abort),
    .vsync_i       (vsync),
    .cfg_o         (cfg_o),
    .pending_o     (pending_o),
    .armed_o       (armed_o),
    .commit_done_o (commit_done_o),
    .timeout_o     (timeout_o)
  );

  typedef struct {
    logic [CW-1:0] cfg;
    int            cyc;
    logic          tmo;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [31:0]   shadow_m [NR];
  logic [CW-1:0] live_m;
  logic          pend_m;
  logic          tmo_m;
  exp_t          sbq [$];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_m();
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NR); k++) v[32*k +: 32] = shadow_m[k];
    return v;
  endfunction

  // One clock; pops the scoreboard on commit_done_o and checks the status outputs
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (commit_done_o === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", CW'(commit_done_o), '0);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", CW'(cyc), CW'(e.cyc));
        live_m = e.cfg;
        pend_m = 1'b0;
        tmo_m  = e.tmo;
      end
    end
    chk("cfg_live", cfg_o, live_m);
    chk("pending", CW'(pending_o), CW'(pend_m));
    chk("timeout", CW'(timeout_o), CW'(tmo_m));
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input bit acc, input string tag);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk({tag, "_ready"}, CW'(wr_ready_o), CW'(acc));
    if (acc && int'(a) < int'(NR)) begin
      shadow_m[int'(a)] = d;
      pend_m = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic arm(input string tag);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk({tag, "_armed"}, CW'(armed_o), CW'(1));
    chk({tag, "_ready_low"}, CW'(wr_ready_o), CW'(0));
  endtask

  // Drive one inactive->active VSYNC transition while armed and expect a commit 2 cycles later
  task automatic edge_commit(input string tag);
    exp_t e;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    e.cfg = pack_m();
    e.cyc = cyc + 2;
    e.tmo = 1'b0;
    sbq.push_back(e);
    tick();
    chk({tag, "_commit_state_armed"}, CW'(armed_o), CW'(0));
    chk({tag, "_commit_state_ready"}, CW'(wr_ready_o), CW'(0));
    tick();
    chk({tag, "_commit_seen"}, CW'(sbq.size()), '0);
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit_req = 1'b0;
    abort      = 1'b0;
    vsync      = 1'b1;
    live_m     = '0;
    pend_m     = 1'b0;
    tmo_m      = 1'b0;
    for (int k = 0; k < int'(NR); k++) shadow_m[k] = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg", cfg_o, '0);
    chk("rst_pending", CW'(pending_o), '0);
    chk("rst_armed", CW'(armed_o), '0);
    chk("rst_done", CW'(commit_done_o), '0);
    chk("rst_timeout", CW'(timeout_o), '0);
    chk("rst_ready", CW'(wr_ready_o), CW'(1));
    rst_n = 1'b1;

    // Basic commit: edge at cycle 50, new cfg and done at cycle 52
    write(AW'(CFG_HV), 32'h0140_00F0, 1'b1, "t1_wr_hv");
    write(AW'(CFG_XY), 32'h0000_0010, 1'b1, "t1_wr_xy");
    arm("t1");
    while (cyc < 49) tick();
    edge_commit("t1");

    // Write refused while armed never reaches cfg_o
    arm("t2");
    write(AW'(CFG_MISC), 32'hDEAD_BEEF, 1'b0, "t2_wr_refused");
    edge_commit("t2");
    chk("t2_misc_word", CW'(cfg_o[31:0]), '0);

    // Abort wins over a same-cycle edge
    write(AW'(CFG_SL), 32'h0000_1234, 1'b1, "t3_wr_sl");
    arm("t3");
    vsync = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_armed", CW'(armed_o), '0);
    chk("t3_ready", CW'(wr_ready_o), CW'(1));
    repeat (3) tick();
    vsync = 1'b1;
    tick();

    // Edge already in progress on the arming cycle is not used
    vsync      = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("t4_armed0", CW'(armed_o), CW'(1));
    repeat (5) tick();
    chk("t4_armed1", CW'(armed_o), CW'(1));
    edge_commit("t4");

    // Out-of-range addresses are accepted and dropped; commit with nothing pending
    write(AW'(9), 32'hBAD0_0009, 1'b1, "t5_wr9");
    write(AW'(15), 32'hBAD0_000F, 1'b1, "t5_wr15");
    arm("t5");
    edge_commit("t5");

    // Back-to-back: held commit_req re-arms on the IDLE cycle after COMMIT
    write(AW'(CFG_MISC), 32'h1111_0000, 1'b1, "t6_wr0");
    write(AW'(CFG_SL2),  32'h2222_0002, 1'b1, "t6_wr2");
    write(AW'(CFG_HV2),  32'h4444_0004, 1'b1, "t6_wr4");
    write(AW'(CFG_HV3),  32'h5555_0005, 1'b1, "t6_wr5");
    write(AW'(CFG_XY2),  32'h7777_0007, 1'b1, "t6_wr7");
    commit_req = 1'b1;
    tick();
    chk("t6_armed", CW'(armed_o), CW'(1));
    begin
      exp_t e;
      vsync = 1'b0;
      e.cfg = pack_m();
      e.cyc = cyc + 2;
      e.tmo = 1'b0;
      sbq.push_back(e);
    end
    tick();
    chk("t6_commit_ready", CW'(wr_ready_o), '0);
    tick();
    chk("t6_commit_seen", CW'(sbq.size()), '0);
    write(AW'(CFG_XY2), 32'hA5A5_0007, 1'b1, "t6_wr_after");
    commit_req = 1'b0;
    chk("t6_rearmed", CW'(armed_o), CW'(1));
    edge_commit("t6b");

`ifdef CFG_COMMIT_TIMEOUT_EN
    // Static VSYNC: timeout forces a commit, next edge commit clears the flag
    begin
      exp_t e;
      write(AW'(CFG_HV), 32'h0BAD_CAFE, 1'b1, "t7_wr");
      e.cfg = pack_m();
      e.cyc = cyc + 18;
      e.tmo = 1'b1;
      sbq.push_back(e);
      arm("t7");
      repeat (20) tick();
      chk("t7_commit_seen", CW'(sbq.size()), '0);
      chk("t7_timeout_flag", CW'(timeout_o), CW'(1));
      arm("t7b");
      edge_commit("t7b");
      chk("t7_timeout_clr", CW'(timeout_o), '0);
    end
`else
    // No timeout: ARMED holds indefinitely with static VSYNC
    arm("t7");
    repeat (40) tick();
    chk("t7_still_armed", CW'(armed_o), CW'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t7_aborted", CW'(armed_o), '0);
`endif

    repeat (3) tick();
    chk("final_sb_empty", CW'(sbq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
